ped_crossing_scheduler: RTL
===========================

// Module: ped_crossing_scheduler
// PURPOSE
//  Timed phase sequencer for a single pedestrian crossing. Latches pedestrian requests from
//  N_REQ push-buttons and enforces a minimum vehicle-green time before serving them. Runs the
//  GREEN->YELLOW->WALK->CLEAR->ALLRED cycle from a 1-cycle-wide tick enable (e.g. 1 Hz).
//  Drives the vehicle lamps and pedestrian signals directly; sits between button debouncers and lamp drivers.
// PARAMETERS
//  N_REQ        2   number of pedestrian request inputs (curb buttons)
//  CNT_W        8   phase timer / countdown width, bits
//  T_MIN_GREEN 20   minimum vehicle green, ticks (>=1)
//  T_YELLOW     4   vehicle yellow, ticks (>=1)
//  T_WALK      10   steady walk, ticks (>=1)
//  T_CLEAR      6   flashing don't-walk clearance, ticks (>=1)
//  T_ALLRED     2   all-red before green returns, ticks (>=1)
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-high
//  tick       in   1      timebase enable; timers advance only on cycles with tick=1
//  ped_req    in   N_REQ  level/pulse request per button, sampled every clk
//  preempt    in   1      emergency preempt; suppresses/shortens pedestrian phase
//  green      out  1      vehicle green
//  yellow     out  1      vehicle yellow
//  red        out  1      vehicle red
//  walk       out  1      pedestrian walk (steady)
//  halt       out  1      pedestrian don't-walk (steady or flashing, see flash_dw)
//  flash_dw   out  1      1 during CLEAR: halt lamp to be flashed by driver
//  ped_pending out 1      a latched request awaits service
//  countdown  out  CNT_W  ticks remaining in current phase (pedestrian display in WALK/CLEAR)
//  phase      out  3      0 GREEN,1 GREEN_HOLD,2 YELLOW,3 WALK,4 CLEAR,5 ALLRED
// BEHAVIOUR
//  - All outputs registered (Moore). Reset (async): phase=GREEN, timer=T_MIN_GREEN-1,
//    green=1, halt=1, others 0, ped_pending=0, countdown=T_MIN_GREEN-1.
//  - Phase entry loads timer=T_x-1. On tick with timer!=0: timer-1. On tick with timer==0: advance.
//    Phase length is exactly T_x ticks; no change occurs on cycles with tick=0.
//  - GREEN: min-green timer. Expiry: pending && !preempt -> YELLOW; else -> GREEN_HOLD.
//  - GREEN_HOLD: timer idle at 0; on first cycle with pending && !preempt -> YELLOW next clk
//    (tick not required).
//  - YELLOW -> WALK -> CLEAR -> ALLRED -> GREEN, each on its own timer expiry.
//  - Lamps: GREEN/GREEN_HOLD green=1,halt=1; YELLOW yellow=1,halt=1; WALK red=1,walk=1;
//    CLEAR red=1,halt=1,flash_dw=1; ALLRED red=1,halt=1. Exactly one vehicle lamp and exactly
//    one of walk/halt high at all times.
//  - Request latch: ped_pending set when any ped_req bit=1 in any phase other than WALK.
//    Cleared on entry to WALK (the same edge). Requests during WALK are ignored (served now);
//    requests in CLEAR/ALLRED are latched for the next cycle.
//  - Simultaneous set and clear on the WALK-entry edge: clear wins.
//  - preempt=1 in GREEN/GREEN_HOLD: stays green and keeps ped_pending. preempt=1 in WALK:
//    next tick forces CLEAR (timer=T_CLEAR-1). preempt does not alter YELLOW/CLEAR/ALLRED.
//  - countdown mirrors timer every cycle; 0 in GREEN_HOLD.
//  - Reset mid-phase: immediate return to reset state; latched request discarded.
//  - Timer values never wrap: decrement only when timer!=0.
// TESTING (bench params: T_MIN_GREEN=3,T_YELLOW=2,T_WALK=3,T_CLEAR=2,T_ALLRED=1; tick every 4 clk)
//  1 Reset, no requests, 20 ticks -> phase GREEN for 3 ticks, then GREEN_HOLD forever; green=1, halt=1.
//  2 ped_req[0] pulse 1 clk at tick 1 -> pending=1; YELLOW after tick 3; WALK 2 ticks later with
//    pending=0 and countdown 2,1,0; then CLEAR 2 ticks with flash_dw=1; ALLRED 1 tick; GREEN.
//  3 In GREEN_HOLD, ped_req[1] pulse between ticks -> YELLOW on next clk, no tick needed.
//  4 ped_req during WALK -> pending stays 0; ped_req during CLEAR -> pending=1, next cycle
//    served after 3-tick min green.
//  5 preempt=1 with pending in GREEN_HOLD -> no YELLOW while high; preempt in WALK -> CLEAR on
//    next tick.
//  6 Assert reset in CLEAR -> outputs at reset values asynchronously; pending=0; lamp one-hot
//    checked every cycle by assertion.

Source files
------------

// File: rtl/ped_crossing_scheduler.sv
// Pedestrian crossing phase sequencer: GREEN -> YELLOW -> WALK -> CLEAR -> ALLRED, timed in ticks.
// All outputs are registered; a latched curb request is served once the minimum green has elapsed.
module ped_crossing_scheduler #(
    parameter int N_REQ       = 2,
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 20,
    parameter int T_YELLOW    = 4,
    parameter int T_WALK      = 10,
    parameter int T_CLEAR     = 6,
    parameter int T_ALLRED    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [N_REQ-1:0] ped_req,
    input  logic             preempt,
    output logic             green,
    output logic             yellow,
    output logic             red,
    output logic             walk,
    output logic             halt,
    output logic             flash_dw,
    output logic             ped_pending,
    output logic [CNT_W-1:0] countdown,
    output logic [2:0]       phase
);

    typedef enum logic [2:0] {
        S_GREEN  = 3'd0,
        S_HOLD   = 3'd1,
        S_YELLOW = 3'd2,
        S_WALK   = 3'd3,
        S_CLEAR  = 3'd4,
        S_ALLRED = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR  = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_pending;
    logic             r_green, r_yellow, r_red, r_walk, r_halt, r_flash;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_pending_nxt;
    logic             w_tmr_zero;
    logic             w_serve;
    logic             w_green, w_yellow, w_red, w_walk, w_halt, w_flash;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_GREEN;
            r_timer   <= LD_GREEN;
            r_pending <= 1'b0;
            r_green   <= 1'b1;
            r_yellow  <= 1'b0;
            r_red     <= 1'b0;
            r_walk    <= 1'b0;
            r_halt    <= 1'b1;
            r_flash   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pending <= w_pending_nxt;
            r_green   <= w_green;
            r_yellow  <= w_yellow;
            r_red     <= w_red;
            r_walk    <= w_walk;
            r_halt    <= w_halt;
            r_flash   <= w_flash;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_pending_nxt = r_pending;
        w_tmr_zero    = (r_timer == '0);
        w_serve       = r_pending && !preempt;
        w_green       = 1'b0;
        w_yellow      = 1'b0;
        w_red         = 1'b0;
        w_walk        = 1'b0;
        w_halt        = 1'b0;
        w_flash       = 1'b0;

        case (r_state)
            S_GREEN: if (tick) begin
                if (!w_tmr_zero) begin
                    w_timer_nxt = r_timer - ONE;
                end else if (w_serve) begin
                    w_state_nxt = S_YELLOW;
                    w_timer_nxt = LD_YELLOW;
                end else begin
                    w_state_nxt = S_HOLD;
                    w_timer_nxt = '0;
                end
            end
            // Minimum green already served: respond on the very next clock, not the next tick.
            S_HOLD: begin
                w_timer_nxt = '0;
                if (w_serve) begin
                    w_state_nxt = S_YELLOW;
                    w_timer_nxt = LD_YELLOW;
                end
            end
            S_YELLOW: if (tick) begin
                if (!w_tmr_zero) begin
                    w_timer_nxt = r_timer - ONE;
                end else begin
                    w_state_nxt = S_WALK;
                    w_timer_nxt = LD_WALK;
                end
            end
            S_WALK: if (tick) begin
                if (preempt || w_tmr_zero) begin
                    w_state_nxt = S_CLEAR;
                    w_timer_nxt = LD_CLEAR;
                end else begin
                    w_timer_nxt = r_timer - ONE;
                end
            end
            S_CLEAR: if (tick) begin
                if (!w_tmr_zero) begin
                    w_timer_nxt = r_timer - ONE;
                end else begin
                    w_state_nxt = S_ALLRED;
                    w_timer_nxt = LD_ALLRED;
                end
            end
            S_ALLRED: if (tick) begin
                if (!w_tmr_zero) begin
                    w_timer_nxt = r_timer - ONE;
                end else begin
                    w_state_nxt = S_GREEN;
                    w_timer_nxt = LD_GREEN;
                end
            end
            default: begin
                w_state_nxt = S_GREEN;
                w_timer_nxt = LD_GREEN;
            end
        endcase

        // Entering WALK serves every waiting pedestrian, so clearing beats a same-cycle press.
        if (w_state_nxt == S_WALK && r_state != S_WALK) begin
            w_pending_nxt = 1'b0;
        end else if (r_state != S_WALK && (|ped_req)) begin
            w_pending_nxt = 1'b1;
        end

        case (w_state_nxt)
            S_GREEN, S_HOLD: begin
                w_green = 1'b1;
                w_halt  = 1'b1;
            end
            S_YELLOW: begin
                w_yellow = 1'b1;
                w_halt   = 1'b1;
            end
            S_WALK: begin
                w_red  = 1'b1;
                w_walk = 1'b1;
            end
            S_CLEAR: begin
                w_red   = 1'b1;
                w_halt  = 1'b1;
                w_flash = 1'b1;
            end
            default: begin
                w_red  = 1'b1;
                w_halt = 1'b1;
            end
        endcase
    end

    assign green       = r_green;
    assign yellow      = r_yellow;
    assign red         = r_red;
    assign walk        = r_walk;
    assign halt        = r_halt;
    assign flash_dw    = r_flash;
    assign ped_pending = r_pending;
    assign countdown   = r_timer;
    assign phase       = r_state;

endmodule
